// File: rtl/echo_timer.sv
// Ultrasonic ping sequencer: burst gating, ring-down blanking, debounced echo capture, no-echo timeout.
// Optional ECHO_SYNC_EN adds a 2-flop synchronizer on echo_in with latency-compensated timing.
module echo_timer #(
    parameter int unsigned BURST_CYCLES    = 1000,
    parameter int unsigned BLANK_CYCLES    = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 2500000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        trigger_in,
    input  logic        echo_in,
    output logic        burst_out,
    output logic [31:0] time_since_emission,
    output logic        echo_detected,
    output logic        timeout_out,
    output logic        busy_out
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] EMIT   = 3'd1;
    localparam logic [2:0] BLANK  = 3'd2;
    localparam logic [2:0] LISTEN = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic echo_q;

`ifdef ECHO_SYNC_EN
    localparam logic [31:0] LAT = 32'd2;
    logic [1:0] sync;
    always_ff @(posedge clk_in) begin
        if (!rst_in) sync <= 2'b00;
        else         sync <= {sync[0], echo_in};
    end
    assign echo_q = sync[1];
`else
    localparam logic [31:0] LAT = 32'd0;
    assign echo_q = echo_in;
`endif

    // Window edges shift by the synchronizer latency so reported times match the pin waveform.
    localparam logic [31:0] BURST_LAST   = 32'(BURST_CYCLES - 1);
    localparam logic [31:0] BLANK_LAST   = 32'(BLANK_CYCLES - 1) + LAT;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1) + LAT;
    localparam logic [31:0] DEB          = 32'(DEBOUNCE_CYCLES);

    logic [2:0]  state;
    logic [31:0] count;
    logic [31:0] run;
    logic [31:0] cand;
    logic [31:0] run_inc;
    logic [31:0] cand_now;
    logic        qualify;

    always_comb begin
        run_inc  = run + 32'd1;
        cand_now = (run == 32'd0) ? (count - LAT) : cand;
        qualify  = (state == LISTEN) && echo_q && (run_inc >= DEB);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state               <= IDLE;
            count               <= 32'd0;
            run                 <= 32'd0;
            cand                <= 32'd0;
            time_since_emission <= 32'd0;
            echo_detected       <= 1'b0;
            timeout_out         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (trigger_in) begin
                        state               <= EMIT;
                        count               <= 32'd0;
                        run                 <= 32'd0;
                        time_since_emission <= 32'd0;
                        echo_detected       <= 1'b0;
                        timeout_out         <= 1'b0;
                    end
                end
                EMIT: begin
                    count <= count + 32'd1;
                    run   <= 32'd0;
                    if (count == BURST_LAST)
                        state <= (BURST_LAST == BLANK_LAST) ? LISTEN : BLANK;
                end
                BLANK: begin
                    count <= count + 32'd1;
                    run   <= 32'd0;
                    if (count == BLANK_LAST) state <= LISTEN;
                end
                LISTEN: begin
                    count <= count + 32'd1;
                    if (qualify) begin
                        state               <= DONE;
                        echo_detected       <= 1'b1;
                        time_since_emission <= cand_now;
                    end else if (count == TIMEOUT_LAST) begin
                        state               <= DONE;
                        timeout_out         <= 1'b1;
                        time_since_emission <= 32'd0;
                    end else if (echo_q) begin
                        run  <= run_inc;
                        cand <= cand_now;
                    end else begin
                        run <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign burst_out = (state == EMIT);
    assign busy_out  = (state == EMIT) || (state == BLANK) || (state == LISTEN);
endmodule

// File: tb/tb_echo_timer.sv
// Bench for echo_timer with small timing parameters; expected ping results go through a scoreboard queue.
module tb_echo_timer;
    localparam int BURST    = 10;
    localparam int BLANK    = 20;
    localparam int DEBOUNCE = 3;
    localparam int TIMEOUT  = 100;
    localparam int LIMIT    = TIMEOUT + 20;
    localparam int NONE     = 100000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        trigger_in = 1'b0;
    logic        echo_in = 1'b0;
    logic        burst_out;
    logic [31:0] time_since_emission;
    logic        echo_detected;
    logic        timeout_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    // {timeout, detected, time_since_emission, done_count}
    logic [65:0] exp_q[$];

    echo_timer #(
        .BURST_CYCLES(BURST),
        .BLANK_CYCLES(BLANK),
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .trigger_in(trigger_in),
        .echo_in(echo_in),
        .burst_out(burst_out),
        .time_since_emission(time_since_emission),
        .echo_detected(echo_detected),
        .timeout_out(timeout_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({burst_out, busy_out, echo_detected, timeout_out, time_since_emission} !== 36'd0) begin
            errors++;
            $display("FAIL %s: burst=%b busy=%b det=%b to=%b tse=%0d, required all zero",
                     name, burst_out, busy_out, echo_detected, timeout_out, time_since_emission);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        trigger_in = 1'b1;
        echo_in = 1'b1;
        step();
        step();
        check_idle_outputs("reset_outputs");
        rst_in = 1'b1;
        trigger_in = 1'b0;
        echo_in = 1'b0;
        step();
        check_idle_outputs("reset_release_idle");
    endtask

    // One ping: trigger, drive the echo pattern by counter value, wait for DONE, compare with the scoreboard.
    task automatic do_ping(input string name, input int echo_start, input int glitch_lo,
                           input int glitch_hi, input int trig_at, input logic exp_to,
                           input logic [31:0] exp_tse, input logic [31:0] exp_done);
        logic [65:0] e;
        int  done_c;
        bit  done;
        exp_q.push_back({exp_to, ~exp_to, exp_tse, exp_done});
        echo_in = 1'b0;
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        checks++;
        if ({busy_out, burst_out, echo_detected, timeout_out, time_since_emission} !== {4'b1100, 32'd0}) begin
            errors++;
            $display("FAIL %s_start: busy=%b burst=%b det=%b to=%b tse=%0d, required busy=1 burst=1 rest 0",
                     name, busy_out, burst_out, echo_detected, timeout_out, time_since_emission);
        end
        done = 1'b0;
        done_c = 0;
        for (int c = 0; c < LIMIT && !done; c++) begin
            echo_in = (c >= echo_start) || (c >= glitch_lo && c <= glitch_hi);
            trigger_in = (c == trig_at);
            checks++;
            if (burst_out !== (c < BURST) || busy_out !== 1'b1) begin
                errors++;
                $display("FAIL %s_burst_busy: count=%0d burst=%b busy=%b, required burst=%b busy=1",
                         name, c, burst_out, busy_out, c < BURST);
            end
            step();
            if (echo_detected === 1'b1 || timeout_out === 1'b1) begin
                done = 1'b1;
                done_c = c;
            end
        end
        trigger_in = 1'b0;
        echo_in = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_no_done: nothing flagged within %0d cycles, required done at count %0d",
                     name, LIMIT, e[31:0]);
            return;
        end
        if ({timeout_out, echo_detected, time_since_emission, 32'(done_c)} !== e || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: to=%b det=%b tse=%0d done=%0d busy=%b, required to=%b det=%b tse=%0d done=%0d busy=0",
                     name, timeout_out, echo_detected, time_since_emission, done_c, busy_out,
                     e[65], e[64], e[63:32], e[31:0]);
        end
        for (int i = 0; i < 4; i++) begin
            echo_in = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({timeout_out, echo_detected, time_since_emission} !== e[65:32] || busy_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: to=%b det=%b tse=%0d busy=%b, required to=%b det=%b tse=%0d busy=0",
                         name, timeout_out, echo_detected, time_since_emission, busy_out,
                         e[65], e[64], e[63:32]);
            end
        end
        echo_in = 1'b0;
    endtask

    task automatic test_basic_echo();
        do_ping("basic", 40, NONE, 0, -1, 1'b0, 32'd40, 32'd42);
    endtask

    task automatic test_glitch();
        do_ping("glitch", 50, 30, 31, -1, 1'b0, 32'd50, 32'd52);
    endtask

    task automatic test_blanking();
        do_ping("blanking", 15, NONE, 0, -1, 1'b0, 32'd20, 32'd22);
    endtask

    task automatic test_timeout();
        do_ping("timeout", NONE, NONE, 0, -1, 1'b1, 32'd0, 32'(TIMEOUT - 1));
    endtask

    task automatic test_retrigger();
        do_ping("retrig_blank", 40, NONE, 0, 15, 1'b0, 32'd40, 32'd42);
        do_ping("retrig_done", 60, NONE, 0, -1, 1'b0, 32'd60, 32'd62);
    endtask

    task automatic test_reset_mid();
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        for (int c = 0; c < 5; c++) step();
        checks++;
        if (burst_out !== 1'b1 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: burst=%b busy=%b, required 1 1", burst_out, busy_out);
        end
        rst_in = 1'b0;
        trigger_in = 1'b1;
        step();
        check_idle_outputs("mid_reset_edge");
        step();
        check_idle_outputs("mid_reset_hold");
        rst_in = 1'b1;
        trigger_in = 1'b0;
        step();
        check_idle_outputs("mid_reset_release");
        do_ping("after_reset", 45, NONE, 0, -1, 1'b0, 32'd45, 32'd47);
    endtask

    initial begin
        test_reset();
        test_basic_echo();
        test_glitch();
        test_blanking();
        test_timeout();
        test_retrigger();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/echo_timer.md
Name: echo_timer

Overview:
- Upstream stage of the range calculator: schedules one ultrasonic ping, gates the transmit burst, blanks transducer ring-down, then qualifies the receive comparator output.
- Produces a frozen cycle count since emission plus a level echo flag. The downstream range stage edge-detects this flag and divides the count.
- Also flags a no-echo timeout so the sweep controller can move on.

Parameters:
- BURST_CYCLES, 1000: cycles burst_out stays high (10 us at 100 MHz).
- BLANK_CYCLES, 50000: echo input ignored while count < BLANK_CYCLES, measured from emission. Must be >= BURST_CYCLES.
- DEBOUNCE_CYCLES, 4: consecutive high samples of echo_in needed to accept an echo. Must be >= 1.
- TIMEOUT_CYCLES, 2500000: maximum listen window from emission (25 ms).

Ports:
- clk_in  input  1  100 MHz system clock.
- rst_in  input  1  Reset. Synchronous, active-low.
- trigger_in  input  1  Single-cycle request to start a ping.
- echo_in  input  1  Thresholded receive envelope, synchronous to clk_in (see optional feature).
- burst_out  output  1  Transmit gate to the 40 kHz burst generator.
- time_since_emission  output  32  Frozen echo arrival count, in cycles since burst start.
- echo_detected  output  1  Level signal: qualified echo captured.
- timeout_out  output  1  Level signal: listen window expired with no echo.
- busy_out  output  1  High in EMIT, BLANK and LISTEN.

Behaviour:
- Reset: rst_in low at a clock edge puts the FSM in IDLE and clears the 32-bit counter and the debounce run counter. All outputs read 0 after that edge. Reset mid-burst drops burst_out on the same edge.
- States: IDLE, EMIT, BLANK, LISTEN, DONE.
- IDLE or DONE with trigger_in=1 at edge T:
  - state becomes EMIT at T+1; counter=0, burst_out=1.
  - echo_detected, timeout_out and time_since_emission clear at T+1.
- trigger_in is ignored in EMIT, BLANK and LISTEN. There is no queueing.
- Counter: increments by 1 every cycle in EMIT, BLANK and LISTEN; it is not wrapped (TIMEOUT_CYCLES bounds it).
- EMIT: burst_out is high for exactly BURST_CYCLES cycles (counter 0 to BURST_CYCLES-1), then BLANK.
- BLANK: echo_in is ignored. Transition to LISTEN on the cycle the counter would reach BLANK_CYCLES, so LISTEN's first cycle has counter = BLANK_CYCLES.
- LISTEN:
  - Run counter increments while echo_in=1 and clears on echo_in=0.
  - The counter value on the first high sample of the current run is latched as the candidate arrival time.
  - When the run reaches DEBOUNCE_CYCLES, the next edge enters DONE with echo_detected=1 and time_since_emission=candidate, both on the same edge. time_since_emission is therefore stable whenever echo_detected is high.
  - If echo_in is already high on entry to LISTEN, the run starts at counter=BLANK_CYCLES.
- Timeout: if LISTEN reaches counter = TIMEOUT_CYCLES-1 without qualification, the next edge enters DONE with timeout_out=1, echo_detected=0, time_since_emission=0.
- Simultaneous events: qualification on the timeout cycle gives echo precedence.
- DONE: outputs are held indefinitely until the next accepted trigger. busy_out=0.
- Widths: the counter is 32-bit unsigned. Parameters must fit in 32 bits, and TIMEOUT_CYCLES > BLANK_CYCLES + DEBOUNCE_CYCLES.

Optional Feature:
- Macro: ECHO_SYNC_EN.
- Defined: echo_in passes through a 2-flop synchronizer before the FSM, so asynchronous comparator pins are safe. The latched candidate is reduced by 2 to compensate, so reported times are identical to the undefined build for the same pin waveform. Detection, timeout and BLANK decisions are made 2 cycles later in absolute time.
- Undefined: echo_in is used directly and must already be synchronous.

Test Plan (BURST=10, BLANK=20, DEBOUNCE=3, TIMEOUT=100):
- Basic echo: trigger at cycle 0; echo_in high from counter 40 onward.
  - burst_out high for counter 0-9.
  - echo_detected rises after the sample at counter 42, with time_since_emission=40.
  - busy_out falls on the same edge.
- Glitch rejection: echo_in high at counter 30-31 only, then high from 50 -> time_since_emission=50. Nothing is flagged at 30.
- Blanking: echo_in high from counter 15 continuously -> time_since_emission=20 and echo_detected set after counter 22. Nothing happens during BLANK.
- Timeout: no echo -> timeout_out=1 after the counter 99 cycle; echo_detected=0 and time_since_emission=0. A later trigger clears timeout_out on the next edge.
- Retrigger/ignore: trigger pulsed in BLANK is ignored (counter continues). In DONE with echo_detected=1, a trigger clears echo_detected next cycle and a second echo at counter 60 reports 60.
- Reset mid-operation: rst_in low during EMIT at counter 5 -> burst_out=0 and busy_out=0 after that edge. trigger_in held high while rst_in is low is ignored; the FSM is in IDLE when rst_in returns high.
